// File: rtl/rc4_prga.sv
`default_nettype none
// ============================================================================
// Module      : rc4_prga
// Description : RC4 pseudo-random generation stage. After the key-scheduling
//               stage has filled the 256x8 S-box, each accepted input byte
//               costs one PRGA step: i/j update, swap of S[i] and S[j], read
//               of S[S[i]+S[j]] and XOR of that keystream byte with the input.
//
// Ports       : clk        - system clock, rising edge
//               rst        - synchronous active-high reset
//               start      - S-box ready pulse, honoured only in IDLE
//               clear      - synchronous abort, same effect as rst
//               din        - input byte (plaintext or ciphertext)
//               din_valid  - din is valid
//               din_ready  - din is accepted this cycle (WAIT_IN only)
//               dout       - din XOR keystream byte
//               dout_valid - dout is valid
//               dout_ready - downstream accepts dout
//               s_addr     - S-box address
//               s_wdata    - S-box write data
//               s_wen      - S-box write enable (read when low)
//               s_rdata    - S-box read data, one cycle after s_addr
//               busy       - high whenever the state is not IDLE
//
// Revision    : 1.0 - initial release
// ============================================================================
module rc4_prga (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       clear,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic [7:0] s_addr,
    output logic [7:0] s_wdata,
    output logic       s_wen,
    input  logic [7:0] s_rdata,
    output logic       busy
);

    localparam logic [3:0] c_IDLE    = 4'd0;
    localparam logic [3:0] c_WAIT_IN = 4'd1;
    localparam logic [3:0] c_RD_A    = 4'd2;
    localparam logic [3:0] c_ISSUE_J = 4'd3;
    localparam logic [3:0] c_RD_B    = 4'd4;
    localparam logic [3:0] c_WR_I    = 4'd5;
    localparam logic [3:0] c_WR_J    = 4'd6;
    localparam logic [3:0] c_ISSUE_K = 4'd7;
    localparam logic [3:0] c_RD_K    = 4'd8;
    localparam logic [3:0] c_OUT     = 4'd9;

    logic [3:0] r_state;
    logic [7:0] r_i;
    logic [7:0] r_j;
    logic [7:0] r_a;        // S[i] captured before the swap
    logic [7:0] r_b;        // S[j] captured before the swap
    logic [7:0] r_byte;     // accepted input byte
    logic [7:0] r_dout;
    logic       r_dout_valid;

    // ------------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            // A swap in flight is simply dropped; the S-box must be rebuilt
            // by the key schedule before the next start.
            r_state      <= c_IDLE;
            r_i          <= 8'd0;
            r_j          <= 8'd0;
            r_a          <= 8'd0;
            r_b          <= 8'd0;
            r_byte       <= 8'd0;
            r_dout       <= 8'd0;
            r_dout_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_i     <= 8'd0;
                        r_j     <= 8'd0;
                        r_state <= c_WAIT_IN;
                    end
                end
                c_WAIT_IN: begin
                    if (din_valid) begin
                        r_byte  <= din;
                        r_i     <= r_i + 8'd1;
                        r_state <= c_RD_A;
                    end
                end
                c_RD_A: begin
                    r_a     <= s_rdata;
                    r_j     <= r_j + s_rdata;
                    r_state <= c_ISSUE_J;
                end
                c_ISSUE_J: begin
                    r_state <= c_RD_B;
                end
                c_RD_B: begin
                    r_b     <= s_rdata;
                    r_state <= c_WR_I;
                end
                c_WR_I: begin
                    r_state <= c_WR_J;
                end
                c_WR_J: begin
                    r_state <= c_ISSUE_K;
                end
                c_ISSUE_K: begin
                    r_state <= c_RD_K;
                end
                c_RD_K: begin
                    // dout_valid is set by the eighth rising edge counting
                    // the din accept edge itself.
                    r_dout       <= r_byte ^ s_rdata;
                    r_dout_valid <= 1'b1;
                    r_state      <= c_OUT;
                end
                c_OUT: begin
                    if (dout_ready) begin
                        r_dout_valid <= 1'b0;
                        r_state      <= c_WAIT_IN;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // S-box port, decoded from registered state only so it is stable at the
    // clock edge. In WAIT_IN the read of S[i+1] is issued speculatively every
    // cycle; it is harmless when no byte arrives.
    // Both swap writes land before ISSUE_K, so the keystream read always sees
    // the post-swap S-box, including the i==j and a+b in {i,j} cases.
    // ------------------------------------------------------------------------
    always_comb begin
        s_addr  = 8'd0;
        s_wdata = 8'd0;
        s_wen   = 1'b0;
        case (r_state)
            c_WAIT_IN: begin
                s_addr = r_i + 8'd1;
            end
            c_ISSUE_J: begin
                s_addr = r_j;
            end
            c_WR_I: begin
                s_addr  = r_i;
                s_wdata = r_b;
                s_wen   = 1'b1;
            end
            c_WR_J: begin
                s_addr  = r_j;
                s_wdata = r_a;
                s_wen   = 1'b1;
            end
            c_ISSUE_K: begin
                s_addr = r_a + r_b;
            end
            default: begin
                s_addr  = 8'd0;
                s_wdata = 8'd0;
                s_wen   = 1'b0;
            end
        endcase
    end

    assign din_ready  = (r_state == c_WAIT_IN);
    assign busy       = (r_state != c_IDLE);
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule
`default_nettype wire

// File: tb/tb_rc4_prga.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc4_prga
// Description : Self-checking bench for rc4_prga. A synchronous-read S-box
//               model is preloaded with the key schedule of key "Key"; known
//               RC4 vectors, swap write trace, latency, backpressure, abort
//               and a long random stream with gaps are checked.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc4_prga;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       clear;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [7:0] s_addr;
    logic [7:0] s_wdata;
    logic       s_wen;
    logic [7:0] s_rdata;
    logic       busy;

    logic       load_req;
    logic       rand_mode;
    logic       mon_en;

    int n_tests = 0;
    int n_fail  = 0;
    int cov_ij  = 0;
    int cov_abij = 0;

    logic [7:0]  sram   [256];
    logic [7:0]  ksa_s  [256];
    logic [7:0]  m_s    [256];
    logic [7:0]  m_i;
    logic [7:0]  m_j;
    logic [7:0]  exp_q  [$];
    logic [15:0] wr_q   [$];
    logic [15:0] mon_w;

    logic [7:0] pt [9]  = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] ct [9]  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] ks [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};

    always #5 clk = ~clk;

    rc4_prga dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clear      (clear),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wen      (s_wen),
        .s_rdata    (s_rdata),
        .busy       (busy)
    );

    // Synchronous-read S-box SRAM with a one-cycle bulk preload.
    always @(posedge clk) begin
        if (load_req) begin
            for (int k = 0; k < 256; k++) sram[k] <= ksa_s[k];
        end else begin
            if (s_wen === 1'b1) sram[s_addr] <= s_wdata;
            s_rdata <= sram[s_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) dout_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Key schedule for key "Key"; also resets the reference PRGA model.
    task automatic load_ksa();
        logic [7:0] key [3];
        logic [7:0] jj;
        logic [7:0] t;
        key[0] = 8'h4B;
        key[1] = 8'h65;
        key[2] = 8'h79;
        for (int k = 0; k < 256; k++) ksa_s[k] = 8'(k);
        jj = 8'd0;
        for (int k = 0; k < 256; k++) begin
            jj        = jj + ksa_s[k] + key[k % 3];
            t         = ksa_s[k];
            ksa_s[k]  = ksa_s[jj];
            ksa_s[jj] = t;
        end
        for (int k = 0; k < 256; k++) m_s[k] = ksa_s[k];
        m_i = 8'd0;
        m_j = 8'd0;
        exp_q.delete();
        wr_q.delete();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // Textbook RC4 PRGA step; queues the two swap writes and the output byte.
    task automatic model_step(input logic [7:0] d, input logic [7:0] exp, input bit use_exp);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] k;
        m_i      = m_i + 8'd1;
        a        = m_s[m_i];
        m_j      = m_j + a;
        b        = m_s[m_j];
        m_s[m_i] = b;
        m_s[m_j] = a;
        k        = a + b;
        if (m_i == m_j) cov_ij++;
        if (k == m_i || k == m_j) cov_abij++;
        wr_q.push_back({m_i, b});
        wr_q.push_back({m_j, a});
        exp_q.push_back(use_exp ? exp : (d ^ m_s[k]));
    endtask

    task automatic send_byte(input logic [7:0] d, input logic [7:0] exp, input bit use_exp);
        int t;
        if (rand_mode) repeat ($urandom_range(0, 2)) tick();
        din       = d;
        din_valid = 1'b1;
        t = 0;
        while (din_ready !== 1'b1 && t < 100) begin
            tick();
            t++;
        end
        if (din_ready === 1'b1) model_step(d, exp, use_exp);
        else check_eq("din_accept_timeout", 32'(din_ready), 1);
        tick();
        din_valid = 1'b0;
        din       = 8'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            tick();
            t++;
        end
        check_eq("drain_outstanding", exp_q.size(), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic restart();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clear_busy", 32'(busy), 0);
        load_ksa();
        pulse_start();
    endtask

    // Write-trace and output scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (s_wen === 1'b1) begin
                if (wr_q.size() == 0) begin
                    check_eq("wr_unexpected", 32'(s_wen), 0);
                end else begin
                    mon_w = wr_q.pop_front();
                    check_eq("wr_addr", 32'(s_addr), 32'(mon_w[15:8]));
                    check_eq("wr_data", 32'(s_wdata), 32'(mon_w[7:0]));
                end
            end
            if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
                if (exp_q.size() == 0) check_eq("dout_unexpected", 32'(dout_valid), 0);
                else check_eq("dout", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int t;
        rst        = 1'b1;
        clear      = 1'b0;
        load_req   = 1'b0;
        rand_mode  = 1'b0;
        mon_en     = 1'b0;
        start      = 1'($urandom);
        din        = 8'($urandom);
        din_valid  = 1'($urandom);
        dout_ready = 1'($urandom);

        // 1. Reset with random inputs
        repeat (2) begin
            @(posedge clk);
            #1;
            start      = 1'($urandom);
            din        = 8'($urandom);
            din_valid  = 1'($urandom);
            dout_ready = 1'($urandom);
        end
        check_eq("rst_dout",       32'(dout),       0);
        check_eq("rst_dout_valid", 32'(dout_valid), 0);
        check_eq("rst_din_ready",  32'(din_ready),  0);
        check_eq("rst_s_wen",      32'(s_wen),      0);
        check_eq("rst_s_addr",     32'(s_addr),     0);
        check_eq("rst_busy",       32'(busy),       0);
        rst        = 1'b0;
        start      = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        mon_en     = 1'b1;
        tick();
        check_eq("idle_no_start_busy", 32'(busy), 0);
        load_ksa();
        pulse_start();
        check_eq("start_busy",      32'(busy),      1);
        check_eq("start_din_ready", 32'(din_ready), 1);

        // 2. Known vector: "Plaintext" under key "Key"
        for (int k = 0; k < 9; k++) send_byte(pt[k], ct[k], 1'b1);
        drain();

        // 3. Keystream with write trace; a stray start mid-stream is ignored
        restart();
        for (int k = 0; k < 10; k++) begin
            send_byte(8'h00, ks[k], 1'b1);
            if (k == 4) pulse_start();
        end
        drain();
        check_eq("wr_trace_left", wr_q.size(), 0);

        // 4. Latency and backpressure
        dout_ready = 1'b0;
        send_byte(8'h3C, 8'h00, 1'b0);
        lat = 0;
        while (dout_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        // Seven edges after the accept edge, i.e. the eighth edge counting it.
        check_eq("latency_edges", lat, 7);
        din       = 8'hA5;
        din_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_eq("stall_dout",       32'(dout),       32'(exp_q[0]));
            check_eq("stall_dout_valid", 32'(dout_valid), 1);
            check_eq("stall_din_ready",  32'(din_ready),  0);
            check_eq("stall_s_wen",      32'(s_wen),      0);
            tick();
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        tick();
        check_eq("release_dout_valid", 32'(dout_valid), 0);
        check_eq("release_din_ready",  32'(din_ready),  1);
        check_eq("release_consumed",   exp_q.size(),    0);

        // 5. Abort during WR_I of byte 3, then restart from i=j=0
        restart();
        send_byte(8'h00, 8'hEB, 1'b1);
        send_byte(8'h00, 8'h9F, 1'b1);
        drain();
        send_byte(8'h00, 8'h77, 1'b1);
        t = 0;
        while (s_wen !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        check_eq("abort_reach_wr_i", 32'(s_wen), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("abort_busy",       32'(busy),       0);
        check_eq("abort_s_wen",      32'(s_wen),      0);
        check_eq("abort_dout_valid", 32'(dout_valid), 0);
        check_eq("abort_din_ready",  32'(din_ready),  0);
        load_ksa();
        pulse_start();
        send_byte(8'h00, 8'hEB, 1'b1);
        drain();

        // 6. Long random stream with gaps across the i/j wraps
        rand_mode = 1'b1;
        for (int k = 0; k < 600; k++) send_byte(8'($urandom), 8'h00, 1'b0);
        drain();
        rand_mode  = 1'b0;
        dout_ready = 1'b1;
        check_eq("rand_wr_trace_left", wr_q.size(), 0);
        $display("[TB] coverage: i==j steps %0d, a+b in {i,j} steps %0d", cov_ij, cov_abij);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
